// File: rtl/ace_snoop_if.sv
// ACE snoop channels (AC request, CR response, CD data) between the interconnect and the snoop unit.
// Every channel: a transfer occurs on the rising edge where valid && ready; once valid is raised the
// sender holds valid and payload stable until that edge, and ready may change freely beforehand.
interface ace_snoop_if #(
   parameter int AC = 64,
   parameter int CD = 64
) ();
   logic [AC-1:0] ac_addr;
   logic [3:0]    ac_snoop;
   logic [2:0]    ac_prot;
   logic          ac_valid;
   logic          ac_ready;
   logic [4:0]    cr_resp;
   logic          cr_valid;
   logic          cr_ready;
   logic [CD-1:0] cd_data;
   logic          cd_last;
   logic          cd_valid;
   logic          cd_ready;

   modport master (
      output ac_addr, ac_snoop, ac_prot, ac_valid,
      input  ac_ready,
      input  cr_resp, cr_valid,
      output cr_ready,
      input  cd_data, cd_last, cd_valid,
      output cd_ready
   );

   modport slave (
      input  ac_addr, ac_snoop, ac_prot, ac_valid,
      output ac_ready,
      output cr_resp, cr_valid,
      input  cr_ready,
      output cd_data, cd_last, cd_valid,
      input  cd_ready
   );
endinterface

// File: rtl/ace_snoop_unit.sv
// ACE snoop engine: queues AC snoops, runs an L1 lookup/invalidate, answers on CR, streams the line on CD.
// Define ACE_SNOOP_ERR_EN to answer unsupported snoop codes with the Error response instead of all-zero.
module ace_snoop_unit #(
   parameter int AC         = 64,
   parameter int CD         = 64,
   parameter int LINE_BYTES = 64,
   parameter int QDEPTH     = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   ace_snoop_if.slave              snp,
   output logic                    lk_req_o,
   output logic [AC-1:0]           lk_addr_o,
   output logic [2:0]              lk_prot_o,
   output logic                    lk_inv_o,
   output logic                    lk_clean_o,
   input  logic                    lk_gnt_i,
   input  logic                    lk_valid_i,
   input  logic                    lk_hit_i,
   input  logic                    lk_dirty_i,
   input  logic                    lk_shared_i,
   input  logic                    lk_unique_i,
   input  logic [LINE_BYTES*8-1:0] lk_line_i,
   output logic [2:0]              dbg_state_o
);
   localparam int LW    = LINE_BYTES * 8;
   localparam int BEATS = LW / CD;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW    = $clog2(QDEPTH);
   localparam logic [AC-1:0] OFF_MASK = AC'(LINE_BYTES - 1);
`ifdef ACE_SNOOP_ERR_EN
   localparam logic [4:0] UNSUP_RESP = 5'b00010;
`else
   localparam logic [4:0] UNSUP_RESP = 5'b00000;
`endif

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DATA} state_e;

   // Returns {supported, invalidate, clean}.
   function automatic logic [2:0] decode(input logic [3:0] code);
      case (code)
         4'b0000, 4'b0001, 4'b0010, 4'b0011: decode = 3'b100;
         4'b0111, 4'b1001, 4'b1101:          decode = 3'b110;
         4'b1000:                            decode = 3'b101;
         default:                            decode = 3'b000;
      endcase
   endfunction

   // {WasUnique, IsShared, PassDirty, Error, DataTransfer} for a supported code.
   function automatic logic [4:0] snoop_resp(input logic [3:0] code, input logic hit, dirty, uniq);
      logic rd, cln, pd, inv;
      rd  = code inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111};
      cln = code inside {4'b1000, 4'b1001};
      pd  = code inside {4'b0111, 4'b1001, 4'b1000, 4'b0001, 4'b0011};
      inv = code inside {4'b0111, 4'b1001, 4'b1101};
      snoop_resp = 5'b00000;
      if (hit) begin
         if (code == 4'b1101) snoop_resp = {uniq, 4'b0000};
         else snoop_resp = {uniq, !inv, dirty && pd, 1'b0, rd || (dirty && cln)};
      end
   endfunction

   logic [AC-1:0]   q_addr  [QDEPTH];
   logic [3:0]      q_snoop [QDEPTH];
   logic [2:0]      q_prot  [QDEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PW:0]     count_q, count_d;
   logic            ac_ready_q;
   logic            push, pop;
   logic [2:0]      head_dec;

   state_e          state_q, state_d;
   logic [AC-1:0]   cmd_addr_q;
   logic [3:0]      cmd_code_q;
   logic [2:0]      cmd_prot_q;
   logic            cmd_inv_q, cmd_clean_q;
   logic [4:0]      resp_q, resp_d;
   logic [LW-1:0]   line_q, line_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic            unused_shared;

   // Shared state does not influence the response; IsShared follows the invalidate decode.
   assign unused_shared = lk_shared_i;

   assign push         = snp.ac_valid && ac_ready_q;
   assign snp.ac_ready = ac_ready_q;
   assign count_d      = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
   assign head_dec     = decode(q_snoop[rd_ptr_q]);
   assign dbg_state_o  = state_q;

   always_ff @(posedge clk_i) begin
      if (push) begin
         q_addr[wr_ptr_q]  <= snp.ac_addr;
         q_snoop[wr_ptr_q] <= snp.ac_snoop;
         q_prot[wr_ptr_q]  <= snp.ac_prot;
      end
   end

   always_comb begin
      state_d       = state_q;
      resp_d        = resp_q;
      line_d        = line_q;
      beat_d        = beat_q;
      pop           = 1'b0;
      lk_req_o      = 1'b0;
      lk_addr_o     = '0;
      lk_prot_o     = 3'b000;
      lk_inv_o      = 1'b0;
      lk_clean_o    = 1'b0;
      snp.cr_valid  = 1'b0;
      snp.cr_resp   = 5'b00000;
      snp.cd_valid  = 1'b0;
      snp.cd_data   = '0;
      snp.cd_last   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop = 1'b1;
               if (head_dec[2]) begin
                  state_d = S_REQ;
               end else begin
                  resp_d  = UNSUP_RESP;
                  state_d = S_RESP;
               end
            end
         end
         S_REQ: begin
            lk_req_o   = 1'b1;
            lk_addr_o  = cmd_addr_q & ~OFF_MASK;
            lk_prot_o  = cmd_prot_q;
            lk_inv_o   = cmd_inv_q;
            lk_clean_o = cmd_clean_q;
            if (lk_gnt_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (lk_valid_i) begin
               resp_d  = snoop_resp(cmd_code_q, lk_hit_i, lk_dirty_i, lk_unique_i);
               line_d  = lk_line_i;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            snp.cr_valid = 1'b1;
            snp.cr_resp  = resp_q;
            beat_d       = '0;
            if (snp.cr_ready) state_d = resp_q[0] ? S_DATA : S_IDLE;
         end
         S_DATA: begin
            snp.cd_valid = 1'b1;
            snp.cd_data  = line_q[int'(beat_q)*CD +: CD];
            snp.cd_last  = (beat_q == BW'(BEATS - 1));
            if (snp.cd_ready) begin
               if (snp.cd_last) begin
                  beat_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ac_ready_q  <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_code_q  <= 4'b0000;
         cmd_prot_q  <= 3'b000;
         cmd_inv_q   <= 1'b0;
         cmd_clean_q <= 1'b0;
         resp_q      <= 5'b00000;
         line_q      <= '0;
         beat_q      <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         resp_q     <= resp_d;
         line_q     <= line_d;
         beat_q     <= beat_d;
         // Ready is registered so it is low while in reset and tracks "not full" afterwards.
         ac_ready_q <= (count_d != (PW+1)'(QDEPTH));
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            cmd_addr_q  <= q_addr[rd_ptr_q];
            cmd_code_q  <= q_snoop[rd_ptr_q];
            cmd_prot_q  <= q_prot[rd_ptr_q];
            cmd_inv_q   <= head_dec[1];
            cmd_clean_q <= head_dec[0];
         end
      end
   end
endmodule

// File: tb/tb_ace_snoop_unit.sv
// Directed bench for ace_snoop_unit: scoreboarded lookup/CR/CD checks, latency, queue full, CD stalls,
// unsupported codes (ACE_SNOOP_ERR_EN aware) and reset abort.
module tb_ace_snoop_unit;
   localparam int AC         = 64;
   localparam int CD         = 64;
   localparam int LINE_BYTES = 64;
   localparam int QDEPTH     = 4;
   localparam int LW         = LINE_BYTES * 8;
   localparam int BEATS      = LW / CD;
`ifdef ACE_SNOOP_ERR_EN
   localparam logic [4:0] UNSUP_RESP = 5'b00010;
`else
   localparam logic [4:0] UNSUP_RESP = 5'b00000;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          lk_req_o, lk_inv_o, lk_clean_o;
   logic [AC-1:0] lk_addr_o;
   logic [2:0]    lk_prot_o;
   logic          lk_gnt_i, lk_valid_i, lk_hit_i, lk_dirty_i, lk_shared_i, lk_unique_i;
   logic [LW-1:0] lk_line_i;
   logic [2:0]    dbg_state_o;

   always #5 clk_i = ~clk_i;

   ace_snoop_if #(.AC(AC), .CD(CD)) snp ();

   ace_snoop_unit #(.AC(AC), .CD(CD), .LINE_BYTES(LINE_BYTES), .QDEPTH(QDEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .snp(snp),
      .lk_req_o(lk_req_o), .lk_addr_o(lk_addr_o), .lk_prot_o(lk_prot_o),
      .lk_inv_o(lk_inv_o), .lk_clean_o(lk_clean_o), .lk_gnt_i(lk_gnt_i),
      .lk_valid_i(lk_valid_i), .lk_hit_i(lk_hit_i), .lk_dirty_i(lk_dirty_i),
      .lk_shared_i(lk_shared_i), .lk_unique_i(lk_unique_i), .lk_line_i(lk_line_i),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- scoreboard state ----------------
   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_xfer = 0;
   logic [4:0]    exp_cr_q[$];
   logic [CD-1:0] exp_cd_q[$];
   logic          exp_last_q[$];
   logic [AC-1:0] exp_lka_q[$];
   logic [4:0]    exp_lkc_q[$];

   // cache model driven by the responder
   logic          m_hit, m_dirty, m_unique, m_shared, gnt_en;
   logic [LW-1:0] m_line;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      l = '0;
      for (int i = 0; i < LW/32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Reference response table, one row per snoop code.
   function automatic logic [4:0] model_resp(input logic [3:0] c, input logic h, d, u);
      logic [4:0] r;
      case (c)
         4'b0000, 4'b0010: r = {u, 1'b1, 1'b0, 1'b0, 1'b1};
         4'b0001, 4'b0011: r = {u, 1'b1, d,    1'b0, 1'b1};
         4'b0111:          r = {u, 1'b0, d,    1'b0, 1'b1};
         4'b1001:          r = {u, 1'b0, d,    1'b0, d};
         4'b1000:          r = {u, 1'b1, d,    1'b0, d};
         4'b1101:          r = {u, 4'b0000};
         default:          r = 5'b11111;
      endcase
      if (r == 5'b11111) r = UNSUP_RESP;
      else if (!h) r = 5'b00000;
      return r;
   endfunction

   task automatic expect_snoop(input logic [AC-1:0] addr, input logic [3:0] code, input logic [2:0] prot);
      logic       sup, inv, cln;
      logic [4:0] r;
      sup = code inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1001, 4'b1000, 4'b1101};
      inv = code inside {4'b0111, 4'b1001, 4'b1101};
      cln = (code == 4'b1000);
      r   = model_resp(code, m_hit, m_dirty, m_unique);
      exp_cr_q.push_back(r);
      if (sup) begin
         exp_lka_q.push_back(addr & ~AC'(LINE_BYTES - 1));
         exp_lkc_q.push_back({prot, inv, cln});
      end
      if (r[0]) begin
         for (int k = 0; k < BEATS; k++) begin
            exp_cd_q.push_back(m_line[k*CD +: CD]);
            exp_last_q.push_back(k == BEATS - 1);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_snoop(input logic [AC-1:0] addr, input logic [3:0] code, input logic [2:0] prot);
      snp.ac_addr  = addr;
      snp.ac_snoop = code;
      snp.ac_prot  = prot;
      snp.ac_valid = 1'b1;
   endtask

   task automatic wait_accept(input string tag);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
         @(negedge clk_i);
         acc = snp.ac_ready;
         @(posedge clk_i);
         #1;
         n++;
      end
      snp.ac_valid = 1'b0;
      chk({tag, "_accept"}, acc, 1'b1);
   endtask

   task automatic send(input string tag, input logic [AC-1:0] addr, input logic [3:0] code,
                       input logic [2:0] prot);
      expect_snoop(addr, code, prot);
      start_snoop(addr, code, prot);
      wait_accept(tag);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk_i);
         #2;
         n++;
      end while ((exp_cr_q.size() + exp_cd_q.size() + exp_lka_q.size() != 0 || dbg_state_o != 3'd0)
                 && n < 600);
      chk({tag, "_drain"}, n < 600, 1'b1);
   endtask

   // Lookup responder: grant in the request cycle, result one cycle after the grant edge.
   always @(posedge clk_i) begin
      logic fire;
      fire = lk_req_o && lk_gnt_i;
      #1;
      lk_gnt_i    = lk_req_o && gnt_en;
      lk_valid_i  = fire;
      lk_hit_i    = fire && m_hit;
      lk_dirty_i  = fire && m_dirty;
      lk_shared_i = fire && m_shared;
      lk_unique_i = fire && m_unique;
      lk_line_i   = fire ? m_line : '0;
   end

   // ---------------- output monitor / scoreboard ----------------
   logic          stall_prev = 1'b0;
   logic [CD-1:0] stall_data;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         stall_prev = 1'b0;
      end else begin
         if (lk_req_o && lk_gnt_i) begin
            chk("lk_expected", exp_lka_q.size() != 0, 1'b1);
            if (exp_lka_q.size() != 0) begin
               chk("lk_addr", lk_addr_o, exp_lka_q.pop_front());
               chk("lk_ctl", {lk_prot_o, lk_inv_o, lk_clean_o}, exp_lkc_q.pop_front());
            end
         end
         if (snp.cr_valid && snp.cr_ready) begin
            chk("cr_expected", exp_cr_q.size() != 0, 1'b1);
            if (exp_cr_q.size() != 0) chk("cr_resp", snp.cr_resp, exp_cr_q.pop_front());
         end
         if (snp.cd_valid) begin
            chk("cr_during_cd", snp.cr_valid, 1'b0);
            if (stall_prev) chk("cd_stable", snp.cd_data, stall_data);
            if (snp.cd_ready) begin
               n_xfer++;
               stall_prev = 1'b0;
               chk("cd_expected", exp_cd_q.size() != 0, 1'b1);
               if (exp_cd_q.size() != 0) begin
                  chk("cd_data", snp.cd_data, exp_cd_q.pop_front());
                  chk("cd_last", snp.cd_last, exp_last_q.pop_front());
               end
            end else begin
               stall_prev = 1'b1;
               stall_data = snp.cd_data;
            end
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int   lat, x0, n;
      logic act;
      rst_ni = 1'b0;
      snp.ac_valid = 1'b0; snp.ac_addr = '0; snp.ac_snoop = 4'b0000; snp.ac_prot = 3'b000;
      snp.cr_ready = 1'b0; snp.cd_ready = 1'b0;
      lk_gnt_i = 1'b0; lk_valid_i = 1'b0; lk_hit_i = 1'b0; lk_dirty_i = 1'b0;
      lk_shared_i = 1'b0; lk_unique_i = 1'b0; lk_line_i = '0;
      m_hit = 1'b0; m_dirty = 1'b0; m_unique = 1'b0; m_shared = 1'b0; m_line = '0; gnt_en = 1'b1;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("reset_ctl", {snp.ac_ready, snp.cr_valid, snp.cr_resp, snp.cd_valid, snp.cd_last,
                        lk_req_o, lk_prot_o, lk_inv_o, lk_clean_o, dbg_state_o}, '0);
      chk("reset_cd_data", snp.cd_data, '0);
      chk("reset_lk_addr", lk_addr_o, '0);
      @(posedge clk_i); #1 rst_ni = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      chk("ac_ready_after_reset", snp.ac_ready, 1'b1);

      // ReadShared hit dirty unique: latency, 5'b11101, 8 beats
      m_hit = 1'b1; m_dirty = 1'b1; m_unique = 1'b1; m_shared = 1'b0; m_line = rand_line();
      @(posedge clk_i); #1;
      snp.cd_ready = 1'b1;
      x0 = n_xfer;
      send("rs", 64'h1040, 4'b0001, 3'b010);
      lat = 0;
      do begin @(posedge clk_i); #1; lat++; end while (!snp.cr_valid && lat < 20);
      chk("rs_latency", lat, 3);
      chk("rs_resp_direct", snp.cr_resp, 5'b11101);
      snp.cr_ready = 1'b1;
      drain("rs");
      chk("rs_beats", n_xfer - x0, 8);

      // ReadOnce to an unaligned address, clean hit not unique
      m_dirty = 1'b0; m_unique = 1'b0; m_line = rand_line();
      send("ro", 64'h2047, 4'b0000, 3'b001);
      drain("ro");

      // MakeInvalid hit unique: no data
      m_dirty = 1'b1; m_unique = 1'b1;
      x0 = n_xfer;
      send("mi", 64'h3000, 4'b1101, 3'b000);
      drain("mi");
      chk("mi_no_cd", n_xfer - x0, 0);

      // ReadUnique miss with delayed grant: request held with invalidate
      m_hit = 1'b0; gnt_en = 1'b0;
      x0 = n_xfer;
      send("ru", 64'h4080, 4'b0111, 3'b100);
      n = 0;
      while (!lk_req_o && n < 20) begin @(posedge clk_i); #1; n++; end
      repeat (3) begin
         @(negedge clk_i);
         chk("ru_req_hold", {lk_req_o, lk_inv_o, lk_clean_o, lk_addr_o}, {3'b110, 64'h4080});
      end
      @(posedge clk_i); #1 gnt_en = 1'b1;
      drain("ru");
      chk("ru_no_cd", n_xfer - x0, 0);

      // Queue fill while CR is stalled, then in-order release
      m_hit = 1'b1; m_dirty = 1'b0; m_unique = 1'b0; m_line = rand_line();
      snp.cr_ready = 1'b0;
      send("qa", 64'h5000, 4'b0001, 3'b000);
      n = 0;
      while (!snp.cr_valid && n < 20) begin @(posedge clk_i); #1; n++; end
      send("qb", 64'h5040, 4'b1000, 3'b001);
      send("qc", 64'h5080, 4'b0010, 3'b010);
      send("qd", 64'h50c0, 4'b1001, 3'b011);
      send("qe", 64'h5100, 4'b0011, 3'b101);
      @(negedge clk_i);
      chk("q_full_ready", snp.ac_ready, 1'b0);
      chk("q_full_state", dbg_state_o, 3'd3);
      expect_snoop(64'h5140, 4'b0000, 3'b110);
      @(posedge clk_i); #1 start_snoop(64'h5140, 4'b0000, 3'b110);
      repeat (3) begin
         @(negedge clk_i);
         chk("q_full_hold", snp.ac_ready, 1'b0);
      end
      @(posedge clk_i); #1 snp.cr_ready = 1'b1;
      wait_accept("qf");
      drain("q");
      chk("q_ready_again", snp.ac_ready, 1'b1);

      // cd_ready toggling during an 8-beat burst
      m_dirty = 1'b1; m_line = rand_line();
      snp.cd_ready = 1'b0;
      x0 = n_xfer;
      send("tg", 64'h6000, 4'b0010, 3'b000);
      n = 0;
      while ((exp_cd_q.size() != 0 || exp_cr_q.size() != 0) && n < 100) begin
         @(posedge clk_i); #1 snp.cd_ready = ~snp.cd_ready;
         n++;
      end
      snp.cd_ready = 1'b1;
      drain("tg");
      chk("tg_beats", n_xfer - x0, 8);

      // Unsupported code: no lookup
      send("uc", 64'h7000, 4'b0101, 3'b000);
      drain("uc");

      // Reset in the middle of a CD burst with another snoop queued
      m_line = rand_line();
      snp.cd_ready = 1'b0;
      send("rr0", 64'h8000, 4'b0001, 3'b000);
      send("rr1", 64'h8040, 4'b0000, 3'b000);
      n = 0;
      while (!snp.cd_valid && n < 20) begin @(posedge clk_i); #1; n++; end
      snp.cd_ready = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 snp.cd_ready = 1'b0;
      @(posedge clk_i); #1 rst_ni = 1'b0;
      @(negedge clk_i);
      chk("rst_mid_ctl", {snp.ac_ready, snp.cr_valid, snp.cr_resp, snp.cd_valid, snp.cd_last,
                          lk_req_o, dbg_state_o}, '0);
      chk("rst_mid_cd_data", snp.cd_data, '0);
      exp_cr_q.delete(); exp_cd_q.delete(); exp_last_q.delete();
      exp_lka_q.delete(); exp_lkc_q.delete();
      snp.cd_ready = 1'b1;
      @(posedge clk_i); #1 rst_ni = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      chk("rst_ready", snp.ac_ready, 1'b1);
      act = 1'b0;
      repeat (20) begin
         @(negedge clk_i);
         act = act | snp.cr_valid | snp.cd_valid | lk_req_o;
      end
      chk("rst_flushed", act, 1'b0);

      // Snoop after reset still works
      m_dirty = 1'b0; m_unique = 1'b1;
      send("post", 64'h9000, 4'b1000, 3'b011);
      drain("post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
